// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver running directly on the system clock.
// Mid-bit sampling is timed from the start edge; each good byte is delivered with a one-cycle strobe.
//
// state | meaning
// IDLE  | line idle; waiting for an armed falling edge
// START | timing to mid start bit to confirm it is still low
// DATA  | sampling 8 data bits LSB first at one-bit intervals
// STOP  | sampling the stop bit; strobe valid or framing error
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx_8n1 #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CPB - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_8n1: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s;
  logic [1:0]       sync_ok;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             armed, armed_next;
  logic [7:0]       data_next;
  logic             valid_next, err_next, busy_next;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    armed_next   = armed;
    data_next    = rx_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (armed && !rx_s) begin
          state_next = START;
          armed_next = 1'b0;
        end else if (rx_s && sync_ok[1]) begin
          // The synchronizer's reset value of 1 must not count as a real idle line.
          armed_next = 1'b1;
        end
      end

      START: begin
        if (cnt == HALF_TC) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_TC) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_TC) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            // High stop level arms an immediately following start edge.
            armed_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        armed_next = 1'b0;
      end
    endcase

    // Busy stays up through the strobe cycle so a consumer sees it cover the whole frame.
    busy_next = (state_next != IDLE) || valid_next || err_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      sync_ok      <= '0;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      armed        <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_busy      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta      <= uart_rx;
      rx_s         <= rx_meta;
      sync_ok      <= {sync_ok[0], 1'b1};
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift_reg    <= shift_next;
      armed        <= armed_next;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_busy      <= busy_next;
      rx_frame_err <= err_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 (CPB=16): frame table plus glitch, break and reset sequences.
// Cycle n is the clock period ending at rising edge n; expected strobes are queued as frames are driven.
module tb_uart_rx_8n1;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;

  uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         idle;
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   busy_low_pending = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge just before the start bit is driven; the next edge is T0.
  task automatic push_exp(input bit is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.cyc    = (cyc + 1) + 3 + HALF + 9 * CPB;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input logic [7:0] exp_data, input bit exp_err);
    push_exp(exp_err, exp_data);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop_ok, CPB);
    uart_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'd0);
  endtask

  // Scoreboard: every strobe must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (busy_low_pending) begin
        check("busy_low_after_valid", 32'(rx_busy), 32'd0);
        busy_low_pending = 1'b0;
      end
      if (rx_valid || rx_frame_err) begin
        check("valid_err_exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({rx_valid, rx_frame_err}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_is_err", 32'(rx_frame_err), 32'(mon_e.is_err));
          check("strobe_is_valid", 32'(rx_valid), 32'(!mon_e.is_err));
          check("rx_data", 32'(rx_data), 32'(mon_e.data));
          check("strobe_cycle", 32'(cyc + 1), 32'(mon_e.cyc));
          check("busy_at_strobe", 32'(rx_busy), 32'd1);
          if (rx_valid) busy_low_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int  t0;
    int  fall;
    bit  seen;
    bit  released;

    vecs[0] = '{8'hA5, 1'b1, 20, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0,  8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 0,  8'h55, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 20, 8'h55, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 20, 8'h81, 1'b0};

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    drive_bit(1'b1, 10);

    // Nominal, back-to-back (no idle gap), framing error, recovery.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].idle > 0) drive_bit(1'b1, vecs[i].idle);
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].exp_data, vecs[i].exp_err);
    end
    drive_bit(1'b1, 20);
    drain("drain_table");

    // Short low glitch is rejected at the mid-start sample.
    t0 = cyc + 1;
    drive_bit(1'b0, 4);
    uart_rx = 1'b1;
    seen = 1'b0;
    fall = -1;
    for (int i = 0; i < 4 * CPB && fall < 0; i++) begin
      if (rx_busy) seen = 1'b1;
      else if (seen) fall = cyc + 1;
      @(negedge clk);
    end
    check("glitch_busy_seen", 32'(seen), 32'd1);
    check("glitch_busy_fall_in_time", 32'(fall >= 0 && (fall - t0) <= HALF + 4), 32'd1);
    drive_bit(1'b1, 20);

    // Break: one framing error, busy held until the line returns high.
    push_exp(1'b1, 8'h81);
    drive_bit(1'b0, 40 * CPB);
    check("break_busy_held", 32'(rx_busy), 32'd1);
    uart_rx = 1'b1;
    released = 1'b0;
    for (int i = 0; i < 8 && !released; i++) begin
      @(negedge clk);
      if (!rx_busy) released = 1'b1;
    end
    check("break_busy_release", 32'(released), 32'd1);
    drive_bit(1'b1, 10);
    send_frame(8'h42, 1'b1, 8'h42, 1'b0);
    drive_bit(1'b1, 20);
    drain("drain_break");

    // Reset in the middle of data bit 3 of 0xC3 while the line keeps toggling.
    d = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(d[i], CPB);
    uart_rx = d[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("midframe_reset");
    repeat (CPB / 2 - 1) @(negedge clk);
    for (int i = 4; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 20);
    check("after_reset_no_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h18, 1'b1, 8'h18, 1'b0);
    drive_bit(1'b1, 20);
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
